sum_capture_fifo: RTL and testbench

// - Downstream consumer of the two-counter sum stage: samples the 4-bit sum on each load strobe.
// - Buffers samples in a small FWFT FIFO and presents each one as two BCD digits (tens/ones)
//   on a valid/ready port for the display/readout logic.
// - Detects when the upstream sum has stopped changing (counters halted) and flags completion.

---
 rtl/sum_capture_fifo_if.sv | 27 ++
 rtl/sum_capture_fifo.sv | 138 +++++++++++++
 tb/tb_sum_capture_fifo.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sum_capture_fifo_if.sv
// Sample/readout bundle between the sum capture FIFO and its producer/consumer.
interface sum_capture_fifo_if #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic              load_w;
    logic [DATA_W-1:0] q_in;
    logic              rd_ready;
    logic              rd_valid;
    logic [3:0]        rd_tens;
    logic [3:0]        rd_ones;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              settled;

    modport master (
        output load_w, q_in, rd_ready,
        input  rd_valid, rd_tens, rd_ones, level, overflow, settled
    );

    modport slave (
        input  load_w, q_in, rd_ready,
        output rd_valid, rd_tens, rd_ones, level, overflow, settled
    );
endinterface

// File: rtl/sum_capture_fifo.sv
// Captures upstream sums into a FWFT FIFO, presents the head as BCD digits,
// and flags when the sampled sum has stopped changing.
//
// state   | meaning
// S_IDLE  | no sample accepted since reset
// S_TRACK | counting consecutive identical accepted samples
// S_DONE  | sum declared settled; terminal until reset
module sum_capture_fifo #(
    parameter int DATA_W     = 4,
    parameter int DEPTH      = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                clk,
    input  logic                reset,
    sum_capture_fifo_if.slave   bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(STABLE_CNT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     head_ptr;
    logic [AW-1:0]     tail_ptr;
    logic [LVL_W-1:0]  level_r;
    logic              overflow_r;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic [DATA_W-1:0] head_val;

    state_t            state, state_nx;
    logic [DATA_W-1:0] last_r, last_nx;
    logic [CNT_W-1:0]  cnt_r, cnt_nx;

    assign empty = (level_r == '0);
    assign full  = (level_r == LVL_W'(DEPTH));
    assign pop   = !empty && bus.rd_ready;
    // A full FIFO still accepts a sample when the head leaves on the same edge.
    assign push  = bus.load_w && (!full || pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[tail_ptr] <= bus.q_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr   <= '0;
            tail_ptr   <= '0;
            level_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push)
                tail_ptr <= tail_ptr + AW'(1);
            if (pop)
                head_ptr <= head_ptr + AW'(1);
            if (push && !pop)
                level_r <= level_r + LVL_W'(1);
            else if (pop && !push)
                level_r <= level_r - LVL_W'(1);
            if (bus.load_w && !push)
                overflow_r <= 1'b1;
        end
    end

    assign head_val = mem[head_ptr];

    always_comb begin
        bus.rd_tens = 4'd0;
        bus.rd_ones = 4'd0;
        if (!empty) begin
            if (head_val >= DATA_W'(10)) begin
                bus.rd_tens = 4'd1;
                bus.rd_ones = 4'(head_val - DATA_W'(10));
            end else begin
                bus.rd_ones = 4'(head_val);
            end
        end
    end

    assign bus.rd_valid = !empty;
    assign bus.level    = level_r;
    assign bus.overflow = overflow_r;
    assign bus.settled  = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            last_r <= '0;
            cnt_r  <= '0;
        end else begin
            state  <= state_nx;
            last_r <= last_nx;
            cnt_r  <= cnt_nx;
        end
    end

    // Only accepted pushes advance the run tracker; dropped samples are invisible here.
    always_comb begin
        state_nx = state;
        last_nx  = last_r;
        cnt_nx   = cnt_r;
        case (state)
            S_IDLE: begin
                if (push) begin
                    last_nx  = bus.q_in;
                    cnt_nx   = CNT_W'(1);
                    state_nx = (STABLE_CNT == 1) ? S_DONE : S_TRACK;
                end
            end
            S_TRACK: begin
                if (push) begin
                    if (bus.q_in == last_r) begin
                        cnt_nx = cnt_r + CNT_W'(1);
                        if (cnt_r + CNT_W'(1) == CNT_W'(STABLE_CNT))
                            state_nx = S_DONE;
                    end else begin
                        last_nx = bus.q_in;
                        cnt_nx  = CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_nx = S_DONE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_sum_capture_fifo.sv
// Scoreboard bench for sum_capture_fifo: directed scenarios followed by randomized traffic.
module tb_sum_capture_fifo;
    localparam int DATA_W     = 4;
    localparam int DEPTH      = 4;
    localparam int STABLE_CNT = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sum_capture_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    sum_capture_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .STABLE_CNT(STABLE_CNT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: sample count, sticky flags, run length of identical accepted samples.
    int ref_level   = 0;
    bit ref_ovf     = 1'b0;
    bit ref_settled = 1'b0;
    int run_len     = 0;
    int last_val    = 0;
    int exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit m_pop, m_push;
        if (reset) begin
            ref_level   = 0;
            ref_ovf     = 1'b0;
            ref_settled = 1'b0;
            run_len     = 0;
            last_val    = 0;
            exp_q.delete();
        end else begin
            m_pop  = (ref_level > 0) && bus.rd_ready;
            m_push = bus.load_w && ((ref_level < DEPTH) || m_pop);
            if (bus.load_w && !m_push)
                ref_ovf = 1'b1;
            if (m_push) begin
                exp_q.push_back(int'(bus.q_in));
                if (run_len > 0 && int'(bus.q_in) == last_val)
                    run_len++;
                else
                    run_len = 1;
                last_val = int'(bus.q_in);
                if (run_len >= STABLE_CNT)
                    ref_settled = 1'b1;
            end
            ref_level = ref_level + int'(m_push) - int'(m_pop);
        end
    end

    always @(negedge clk) begin
        int v;
        if (!reset) begin
            chk("rd_valid", int'(bus.rd_valid), int'(ref_level > 0));
            chk("level", int'(bus.level), ref_level);
            chk("overflow", int'(bus.overflow), int'(ref_ovf));
            chk("settled", int'(bus.settled), int'(ref_settled));
            if (bus.rd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard: rd_valid=1 but no sample expected at %0t", $time);
                end else begin
                    v = exp_q[0];
                    chk("rd_tens", int'(bus.rd_tens), (v >= 10) ? 1 : 0);
                    chk("rd_ones", int'(bus.rd_ones), v % 10);
                    if (bus.rd_ready)
                        void'(exp_q.pop_front());
                end
            end else begin
                chk("rd_tens_empty", int'(bus.rd_tens), 0);
                chk("rd_ones_empty", int'(bus.rd_ones), 0);
            end
        end
    end

    task automatic step(input bit l, input int q, input bit r);
        bus.load_w   = l;
        bus.q_in     = DATA_W'(q);
        bus.rd_ready = r;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load_w   = 1'b0;
        bus.q_in     = '0;
        bus.rd_ready = 1'b0;
        reset        = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        reset = 1'b0;

        repeat (5) step(0, 0, 0);
        chk("reset_rd_valid", int'(bus.rd_valid), 0);
        chk("reset_level", int'(bus.level), 0);
        chk("reset_overflow", int'(bus.overflow), 0);
        chk("reset_settled", int'(bus.settled), 0);

        step(1, 7, 0);
        step(1, 12, 0);
        chk("two_level", int'(bus.level), 2);
        chk("two_head_ones", int'(bus.rd_ones), 7);
        step(0, 0, 1);
        chk("second_tens", int'(bus.rd_tens), 1);
        chk("second_ones", int'(bus.rd_ones), 2);
        step(0, 0, 1);
        chk("drained_valid", int'(bus.rd_valid), 0);

        for (int i = 1; i <= 5; i++) step(1, i, 0);
        chk("full_level", int'(bus.level), 4);
        chk("full_overflow", int'(bus.overflow), 1);
        repeat (4) step(0, 0, 1);

        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 10 + i, 0);
        step(1, 9, 1);
        chk("pushpop_full_level", int'(bus.level), 4);
        chk("pushpop_full_overflow", int'(bus.overflow), 0);
        repeat (4) step(0, 0, 1);

        do_reset();
        repeat (3) step(1, 13, 0);
        chk("settle_after_third", int'(bus.settled), 1);
        step(1, 14, 0);
        chk("settle_held", int'(bus.settled), 1);
        chk("settle_fifo_level", int'(bus.level), 4);
        repeat (4) step(0, 0, 1);

        do_reset();
        step(1, 15, 0);
        step(1, 15, 0);
        do_reset();
        step(1, 15, 0);
        chk("post_reset_settled", int'(bus.settled), 0);
        chk("post_reset_level", int'(bus.level), 1);
        chk("post_reset_tens", int'(bus.rd_tens), 1);
        chk("post_reset_ones", int'(bus.rd_ones), 5);
        step(0, 0, 1);

        for (int n = 0; n < 3000; n++) begin
            int q;
            bit l, r;
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                l = ($urandom_range(0, 1) == 1);
                q = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                                : int'($urandom_range(12, 13));
                if ((n / 300) % 2 == 0)
                    r = ($urandom_range(0, 3) != 0);
                else
                    r = ($urandom_range(0, 3) == 0);
                step(l, q, r);
            end
        end

        repeat (DEPTH + 2) step(0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
